// File: rtl/alu_op_issue_pkg.sv
// Shared types and constants for the ID/EX ALU operation issuer.
// ALUOp encodings match the EX-stage ALU; funct3 values follow the RV64 base ISA.
package alu_op_issue_pkg;

  localparam int XLEN = 64;
  localparam int OP_W = 4;

  typedef logic [OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_AND = 4'b0000;
  localparam alu_op_t ALU_OR  = 4'b0001;
  localparam alu_op_t ALU_ADD = 4'b0010;
  localparam alu_op_t ALU_SUB = 4'b0110;
  localparam alu_op_t ALU_NOR = 4'b1100;
  localparam alu_op_t ALU_SLL = 4'b0111;

  // Instruction class produced by the main control unit.
  typedef enum logic [1:0] {
    CTRL_MEM = 2'b00,
    CTRL_BR  = 2'b01,
    CTRL_R   = 2'b10,
    CTRL_I   = 2'b11
  } alu_ctrl_e;

  // Branch-type funct3 values, forwarded untouched on br_type.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Arithmetic funct3 values understood by the decoder.
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    alu_op_t         alu_op;
    logic            is_branch;
    logic [2:0]      br_type;
    logic            illegal;
  } idex_t;

  // A bubble looks like a harmless ADD of zeros and can never resolve a branch.
  function automatic idex_t idex_bubble();
    idex_t b;
    b           = '0;
    b.alu_op    = ALU_ADD;
    return b;
  endfunction

endpackage

// File: rtl/alu_op_issue_if.sv
// ID-stage to EX-stage bundle: decode inputs, hazard controls and registered ALU operands.
// master = ID stage / hazard unit side, slave = the issuer.
interface alu_op_issue_if;
  import alu_op_issue_pkg::*;

  logic            in_valid;
  logic [1:0]      alu_ctrl;
  logic [2:0]      funct3;
  logic            funct7_b5;
  logic            alu_src;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            stall;
  logic            flush;

  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  alu_op_t         alu_op;
  logic            is_branch;
  logic [2:0]      br_type;
  logic            illegal;

  modport master (
    output in_valid, alu_ctrl, funct3, funct7_b5, alu_src,
           rs1_data, rs2_data, imm, stall, flush,
    input  in_ready, out_valid, op_a, op_b, alu_op, is_branch, br_type, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, funct3, funct7_b5, alu_src,
           rs1_data, rs2_data, imm, stall, flush,
    output in_ready, out_valid, op_a, op_b, alu_op, is_branch, br_type, illegal
  );

endinterface

// File: rtl/alu_op_issue_decode.sv
// Combinational ALU control: instruction class plus funct3/funct7[5] to ALUOp.
// Unsupported R/I combinations fall back to ADD and raise illegal.
module alu_op_decode
  import alu_op_issue_pkg::*;
(
  input  alu_ctrl_e  alu_ctrl,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output alu_op_t    alu_op,
  output logic       illegal,
  output logic       is_branch
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    alu_op    = ALU_ADD;
    illegal   = 1'b0;
    is_branch = 1'b0;

    case (alu_ctrl)
      CTRL_MEM: alu_op = ALU_ADD;

      CTRL_BR: begin
        alu_op    = ALU_SUB;
        is_branch = 1'b1;
      end

      CTRL_R: begin
        case ({funct3, funct7_b5})
          {F3_ADD, 1'b0}: alu_op = ALU_ADD;
          {F3_ADD, 1'b1}: alu_op = ALU_SUB;
          {F3_AND, 1'b0}: alu_op = ALU_AND;
          {F3_OR,  1'b0}: alu_op = ALU_OR;
          {F3_SLL, 1'b0}: alu_op = ALU_SLL;
          default:        illegal = 1'b1;
        endcase
      end

      CTRL_I: begin
        // For I-type, bit 30 is immediate payload except on the shift encoding.
        case (funct3)
          F3_ADD: alu_op = ALU_ADD;
          F3_AND: alu_op = ALU_AND;
          F3_OR:  alu_op = ALU_OR;
          F3_SLL: begin
            if (!funct7_b5) alu_op  = ALU_SLL;
            else            illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end

      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX issuer: decodes ALUOp, muxes operand B and holds the ID/EX register
// with hazard-unit stall (hold) and flush (bubble); flush beats stall.
module alu_op_issue
  import alu_op_issue_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  alu_op_issue_if.slave bus
);

  alu_op_t         dec_alu_op;
  logic            dec_illegal;
  logic            dec_is_branch;
  logic [XLEN-1:0] op_b_sel;

  idex_t idex_d;
  idex_t idex_q;

  alu_op_decode u_decode (
    .alu_ctrl  (alu_ctrl_e'(bus.alu_ctrl)),
    .funct3    (bus.funct3),
    .funct7_b5 (bus.funct7_b5),
    .alu_op    (dec_alu_op),
    .illegal   (dec_illegal),
    .is_branch (dec_is_branch)
  );

  assign op_b_sel = bus.alu_src ? bus.imm : bus.rs2_data;

  always_comb begin
    idex_d = idex_q;
    if (bus.flush) begin
      idex_d = idex_bubble();
    end else if (!bus.stall) begin
      if (bus.in_valid) begin
        idex_d.valid     = 1'b1;
        idex_d.op_a      = bus.rs1_data;
        idex_d.op_b      = op_b_sel;
        idex_d.alu_op    = dec_alu_op;
        idex_d.is_branch = dec_is_branch;
        idex_d.br_type   = dec_is_branch ? bus.funct3 : 3'b000;
        idex_d.illegal   = dec_illegal;
      end else begin
        idex_d = idex_bubble();
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    if (!reset_n) idex_q <= '0;
    else          idex_q <= idex_d;
  end

  // Stall back-pressures ID; a flush alone lets ID keep advancing.
  assign bus.in_ready  = ~bus.stall;
  assign bus.out_valid = idex_q.valid;
  assign bus.op_a      = idex_q.op_a;
  assign bus.op_b      = idex_q.op_b;
  assign bus.alu_op    = idex_q.alu_op;
  assign bus.is_branch = idex_q.is_branch;
  assign bus.br_type   = idex_q.br_type;
  assign bus.illegal   = idex_q.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue: reset, decode, branch,
// stall, flush priority, bubbles and asynchronous reset.
module tb_alu_op_issue;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  alu_op_issue_if bus ();

  alu_op_issue dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {out_valid, alu_op, is_branch, br_type, illegal, op_a, op_b}
  typedef logic [137:0] obs_t;

  function automatic obs_t pack(input logic v, input logic [3:0] op, input logic br,
                                input logic [2:0] bt, input logic ill,
                                input logic [63:0] a, input logic [63:0] b);
    return {v, op, br, bt, ill, a, b};
  endfunction

  function automatic obs_t observed();
    return pack(bus.out_valid, bus.alu_op, bus.is_branch, bus.br_type, bus.illegal,
                bus.op_a, bus.op_b);
  endfunction

  // Bubble checks ignore br_type: a bubble has is_branch=0, so br_type carries no meaning.
  function automatic obs_t observed_no_bt();
    return pack(bus.out_valid, bus.alu_op, bus.is_branch, 3'b000, bus.illegal,
                bus.op_a, bus.op_b);
  endfunction

  task automatic drive(input logic v, input logic [1:0] ctrl, input logic [2:0] f3,
                       input logic f7, input logic src, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] im);
    bus.in_valid  = v;
    bus.alu_ctrl  = ctrl;
    bus.funct3    = f3;
    bus.funct7_b5 = f7;
    bus.alu_src   = src;
    bus.rs1_data  = a;
    bus.rs2_data  = b;
    bus.imm       = im;
  endtask

  task automatic test_reset();
    obs_t exp;
    reset_n   = 1'b0;
    bus.stall = 1'($urandom);
    bus.flush = 1'($urandom);
    drive(1'b1, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (3) @(posedge clk);
    #1;
    exp = pack(1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 64'd0, 64'd0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", observed(), exp);
    end

    @(negedge clk);
    reset_n   = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 64'd10, 64'd3, 64'd99);
    @(posedge clk);
    #1;
    exp = pack(1'b1, 4'b0110, 1'b0, 3'b000, 1'b0, 64'd10, 64'd3);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL first_sub_after_reset: got %h expected %h", observed(), exp);
    end
  endtask

  typedef struct {
    logic [1:0]  ctrl;
    logic [2:0]  f3;
    logic        f7;
    logic        src;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] im;
    logic [3:0]  op;
    logic        ill;
  } vec_t;

  task automatic test_decode();
    vec_t tbl[12];
    obs_t exp;
    logic [63:0] exp_b;
    //          ctrl   f3      f7    src   rs1           rs2         imm                     op       ill
    tbl[0]  = '{2'b10, 3'b111, 1'b0, 1'b0, 64'hF0F0,     64'h0FF0,   64'h1,                  4'b0000, 1'b0};
    tbl[1]  = '{2'b10, 3'b110, 1'b0, 1'b0, 64'h1234,     64'h4321,   64'h2,                  4'b0001, 1'b0};
    tbl[2]  = '{2'b10, 3'b001, 1'b0, 1'b0, 64'h1,        64'd5,      64'h3,                  4'b0111, 1'b0};
    tbl[3]  = '{2'b11, 3'b000, 1'b0, 1'b1, 64'd7,        64'd8,      64'hFFFF_FFFF_FFFF_FFFF, 4'b0010, 1'b0};
    tbl[4]  = '{2'b10, 3'b101, 1'b0, 1'b0, 64'd11,       64'd12,     64'd13,                 4'b0010, 1'b1};
    tbl[5]  = '{2'b10, 3'b111, 1'b1, 1'b0, 64'd21,       64'd22,     64'd23,                 4'b0010, 1'b1};
    tbl[6]  = '{2'b11, 3'b001, 1'b1, 1'b1, 64'd31,       64'd32,     64'd33,                 4'b0010, 1'b1};
    tbl[7]  = '{2'b11, 3'b001, 1'b0, 1'b1, 64'd41,       64'd42,     64'd4,                  4'b0111, 1'b0};
    tbl[8]  = '{2'b11, 3'b000, 1'b1, 1'b1, 64'd51,       64'd52,     64'h8000_0000_0000_0000, 4'b0010, 1'b0};
    tbl[9]  = '{2'b11, 3'b111, 1'b1, 1'b1, 64'd61,       64'd62,     64'hFF,                 4'b0000, 1'b0};
    tbl[10] = '{2'b11, 3'b100, 1'b0, 1'b1, 64'd71,       64'd72,     64'd73,                 4'b0010, 1'b1};
    tbl[11] = '{2'b00, 3'b011, 1'b1, 1'b1, 64'h1000,     64'd82,     64'hFFFF_FFFF_FFFF_FFF8, 4'b0010, 1'b0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b1, tbl[i].ctrl, tbl[i].f3, tbl[i].f7, tbl[i].src, tbl[i].a, tbl[i].b, tbl[i].im);
      @(posedge clk);
      #1;
      exp_b = tbl[i].src ? tbl[i].im : tbl[i].b;
      exp   = pack(1'b1, tbl[i].op, 1'b0, 3'b000, tbl[i].ill, tbl[i].a, exp_b);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL decode_vec%0d: got %h expected %h", i, observed(), exp);
      end
    end

    // in_valid=0 captures a bubble even with a live-looking branch on the inputs.
    @(negedge clk);
    drive(1'b0, 2'b01, 3'b101, 1'b0, 1'b0, 64'd9, 64'd9, 64'd9);
    @(posedge clk);
    #1;
    exp = pack(1'b0, 4'b0010, 1'b0, 3'b000, 1'b0, 64'd0, 64'd0);
    checks++;
    if (observed_no_bt() !== exp) begin
      errors++;
      $display("FAIL invalid_bubble: got %h expected %h", observed_no_bt(), exp);
    end
  endtask

  task automatic test_branch();
    obs_t exp;
    @(negedge clk);
    drive(1'b1, 2'b01, 3'b001, 1'b0, 1'b0, 64'd5, 64'd5, 64'd77);
    @(posedge clk);
    #1;
    exp = pack(1'b1, 4'b0110, 1'b1, 3'b001, 1'b0, 64'd5, 64'd5);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL branch_bne: got %h expected %h", observed(), exp);
    end

    @(negedge clk);
    drive(1'b1, 2'b01, 3'b111, 1'b1, 1'b0, 64'd3, 64'd9, 64'd1);
    @(posedge clk);
    #1;
    exp = pack(1'b1, 4'b0110, 1'b1, 3'b111, 1'b0, 64'd3, 64'd9);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL branch_bgeu: got %h expected %h", observed(), exp);
    end
  endtask

  task automatic test_stall();
    obs_t exp_add;
    obs_t exp_sub;
    @(negedge clk);
    drive(1'b1, 2'b00, 3'b010, 1'b0, 1'b0, 64'd100, 64'd25, 64'd4);
    @(posedge clk);
    #1;
    exp_add = pack(1'b1, 4'b0010, 1'b0, 3'b000, 1'b0, 64'd100, 64'd25);
    checks++;
    if (observed() !== exp_add) begin
      errors++;
      $display("FAIL stall_capture_add: got %h expected %h", observed(), exp_add);
    end

    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.stall = 1'b1;
      drive(1'b1, 2'b10, 3'b000, 1'b1, 1'b0, 64'd200 + 64'(c), 64'd50, 64'd0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready%0d: got %b expected 0", c, bus.in_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (observed() !== exp_add) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h expected %h", c, observed(), exp_add);
      end
    end

    @(negedge clk);
    bus.stall = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL unstall_in_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    exp_sub = pack(1'b1, 4'b0110, 1'b0, 3'b000, 1'b0, 64'd202, 64'd50);
    checks++;
    if (observed() !== exp_sub) begin
      errors++;
      $display("FAIL unstall_sub: got %h expected %h", observed(), exp_sub);
    end
  endtask

  task automatic test_flush();
    obs_t exp;
    obs_t bubble;
    bubble = pack(1'b0, 4'b0010, 1'b0, 3'b000, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 64'd8, 64'd8, 64'd0);
    @(posedge clk);
    #1;
    exp = pack(1'b1, 4'b0110, 1'b1, 3'b000, 1'b0, 64'd8, 64'd8);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL flush_setup_branch: got %h expected %h", observed(), exp);
    end

    @(negedge clk);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (observed_no_bt() !== bubble) begin
      errors++;
      $display("FAIL flush_over_stall: got %h expected %h", observed_no_bt(), bubble);
    end

    // Flush alone: in_ready stays high, and the illegal capture is squashed.
    @(negedge clk);
    bus.stall = 1'b0;
    drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b0, 64'd1, 64'd2, 64'd3);
    @(posedge clk);
    #1;
    exp = pack(1'b1, 4'b0010, 1'b0, 3'b000, 1'b1, 64'd1, 64'd2);
    @(negedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (observed_no_bt() !== bubble) begin
      errors++;
      $display("FAIL flush_alone: got %h expected %h", observed_no_bt(), bubble);
    end
    checks++;
    if (exp[128] !== 1'b1) begin
      errors++;
      $display("FAIL flush_expect_sanity: got %b expected 1", exp[128]);
    end
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic test_async_reset();
    obs_t exp;
    @(negedge clk);
    bus.stall = 1'b1;
    drive(1'b1, 2'b11, 3'b110, 1'b0, 1'b1, 64'd6, 64'd0, 64'd9);
    @(posedge clk);
    bus.stall = 1'b0;
    @(posedge clk);
    #1;
    exp = pack(1'b1, 4'b0001, 1'b0, 3'b000, 1'b0, 64'd6, 64'd9);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL async_setup_or: got %h expected %h", observed(), exp);
    end

    #2;
    bus.stall = 1'b1;
    reset_n   = 1'b0;
    #1;
    exp = pack(1'b0, 4'b0000, 1'b0, 3'b000, 1'b0, 64'd0, 64'd0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL async_reset_clear: got %h expected %h", observed(), exp);
    end

    @(negedge clk);
    reset_n   = 1'b1;
    bus.stall = 1'b0;
    drive(1'b1, 2'b10, 3'b001, 1'b0, 1'b0, 64'd1, 64'd63, 64'd0);
    @(posedge clk);
    #1;
    exp = pack(1'b1, 4'b0111, 1'b0, 3'b000, 1'b0, 64'd1, 64'd63);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL after_async_sll: got %h expected %h", observed(), exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    test_reset();
    test_decode();
    test_branch();
    test_stall();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
Name: alu_op_issue

Overview:
- ID/EX-side issuer that drives the 64-bit EX-stage ALU.
- Decodes the main-control 2-bit alu_ctrl plus funct3/funct7[5] into the ALU's 4-bit ALUOp.
- Selects operand B (rs2 or immediate) and registers operands, ALUOp and branch type into the ID/EX pipeline register.
- Supports stall (hold) and flush (bubble) from the hazard unit.

Parameters:
XLEN, 64, operand width
OP_W, 4, ALUOp width

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  ID stage holds a valid instruction
alu_ctrl  in  2  main-control class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU
funct3  in  3  instruction[14:12]
funct7_b5  in  1  instruction[30]
alu_src  in  1  1 = operand B from imm, 0 = from rs2
rs1_data  in  XLEN  register-file read 1
rs2_data  in  XLEN  register-file read 2
imm  in  XLEN  sign-extended immediate
stall  in  1  hazard unit: hold ID/EX contents
flush  in  1  hazard unit: replace ID/EX with a bubble
in_ready  out  1  ID may advance; equals ~stall
out_valid  out  1  ID/EX holds a valid instruction
op_a  out  XLEN  registered ALU input a
op_b  out  XLEN  registered ALU input b
alu_op  out  OP_W  registered ALUOp
is_branch  out  1  registered: instruction is a branch
br_type  out  3  registered funct3 for branch resolution (Zero/Is_Greater consumer)
illegal  out  1  registered: unsupported funct combination captured

Behaviour:
- Reset (reset_n low, asynchronous): all outputs 0, including out_valid=0, alu_op=0000, op_a/op_b=0, illegal=0.
- Decode is combinational; its result is registered, giving 1-cycle latency from ID inputs to outputs.
- ALUOp encodings: AND=0000, OR=0001, ADD=0010, SUB=0110, NOR=1100, SLL=0111. NOR is never produced by this block.
- alu_ctrl=00: ADD.
- alu_ctrl=01: SUB, is_branch=1, br_type=funct3.
- alu_ctrl=10, by funct3/funct7_b5:
  - 000/0 → ADD; 000/1 → SUB
  - 111/0 → AND
  - 110/0 → OR
  - 001/0 → SLL
  - anything else → ADD with illegal=1
- alu_ctrl=11, by funct3 (funct7_b5 ignored except for 001):
  - 000 → ADD; 111 → AND; 110 → OR
  - 001 with funct7_b5=0 → SLL
  - anything else → ADD with illegal=1
- op_a = rs1_data. op_b = alu_src ? imm : rs2_data, selected before the register.
- Each rising clk, the ID/EX register updates in priority order:
  1. flush=1: out_valid←0, is_branch←0, illegal←0, alu_op←ADD, op_a/op_b←0. Flush wins over stall.
  2. stall=1: all registers hold their values.
  3. Otherwise: capture decode. out_valid←in_valid. When in_valid=0, capture a bubble identical to the flush bubble.
- in_ready = ~stall, purely combinational. flush does not deassert in_ready.
- Bubbles never assert is_branch or illegal, so a bubble cannot resolve a branch.
- Asynchronous reset mid-stall or mid-flush clears everything immediately. Deassertion takes effect at the next edge with normal priority.
- Operand widths are fixed at XLEN. No truncation or extension inside the block.

Decomposition:
- Shared package holds:
  - ALUOp localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_SLL
  - alu_ctrl class constants: CTRL_MEM, CTRL_BR, CTRL_R, CTRL_I
  - funct3 constants for branch types
- One natural sub-module: alu_op_decode, purely combinational (alu_ctrl, funct3, funct7_b5 → alu_op, illegal, is_branch). alu_op_issue instantiates it and adds the operand mux and the ID/EX register with stall/flush.

Test Plan:
- Reset: hold reset_n=0 with random inputs → out_valid=0, alu_op=0000, op_a=op_b=0. Release, then in_valid=1, alu_ctrl=10, funct3=000, funct7_b5=1, rs1=10, rs2=3 → next cycle alu_op=0110, op_a=10, op_b=3, out_valid=1.
- Decode sweep: R-type 111/0→0000, 110/0→0001, 001/0→0111. I-type funct3=000, alu_src=1, imm=0xFFFF_FFFF_FFFF_FFFF → alu_op=0010, op_b=all ones. R-type 101/0 → alu_op=0010, illegal=1.
- Branch: alu_ctrl=01, funct3=001, rs1=5, rs2=5 → alu_op=0110, is_branch=1, br_type=001, op_a=op_b=5.
- Stall: capture an ADD, then stall=1 for 3 cycles while inputs change to SUB → outputs hold ADD values, in_ready=0. Drop stall → SUB captured next edge.
- Flush over stall: stall=1 and flush=1 together → next cycle out_valid=0, is_branch=0, alu_op=0010, op_a=op_b=0.
- Async reset mid-operation: assert reset_n=0 between clock edges while out_valid=1 → outputs clear before the next edge.
